// File: rtl/decode_stage.sv
// RV32I instruction-decode stage between IF and EX: field decode, register read,
// immediate select, branch resolution, load-use interlock and a one-entry EX request register.
package decode_stage_pkg;
  typedef struct packed {
    logic       mem_en;
    logic       ex_en;
    logic       wb_en;
    logic       imm_en;
    logic       valid;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
  } ctrl_t;
endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RAW      = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                                     iClk,
  input  logic                                     nRst,
  input  logic                                     iFlush,
  input  logic                                     iValid,
  output logic                                     oReady,
  input  logic [31:0]                              iInstr,
  input  logic [XLEN-1:0]                          iPC,
  output logic [RAW-1:0]                           oAddrRs1,
  output logic [RAW-1:0]                           oAddrRs2,
  input  logic [XLEN-1:0]                          iRs1,
  input  logic [XLEN-1:0]                          iRs2,
  output logic                                     oValid,
  input  logic                                     iReady,
  output logic [$bits(ctrl_t)+3*RAW+3*XLEN-1:0]    oEX,
  output logic [XLEN-1:0]                          oPC,
  output logic                                     oBrTrue,
  output logic                                     oIllegal,
  output logic                                     oHzStall
);

  typedef struct packed {
    logic [XLEN-1:0] value;
    logic [RAW-1:0]  addr;
  } rs_t;

  typedef struct packed {
    ctrl_t           ctrl;
    rs_t             rs1;
    rs_t             rs2;
    logic [RAW-1:0]  rd_addr;
    logic [XLEN-1:0] immediate;
  } id_ex_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;

  localparam int CNT_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic br_outcome(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                      input logic [2:0] f3);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic            fmt_i, fmt_u, fmt_r, fmt_b, fmt_j, fmt_s, legal;
  logic            rs1_en, rs2_en, rd_en, is_load, accept, br_taken;
  logic [XLEN-1:0] imm;
  id_ex_t          dec;
  id_ex_t          ex_p1;
  logic [CNT_W-1:0] cnt;
  logic [RAW-1:0]  lat_rd;

  // Stage p0: combinational decode of the instruction presented by IF
  assign opcode  = iInstr[6:0];
  assign fmt_i   = opcode inside {OP_ALUI, OP_JALR, OP_LOAD};
  assign fmt_u   = opcode inside {OP_LUI, OP_AUIPC};
  assign fmt_r   = (opcode == OP_ALUR);
  assign fmt_b   = (opcode == OP_BRANCH);
  assign fmt_j   = (opcode == OP_JAL);
  assign fmt_s   = (opcode == OP_STORE);
  assign legal   = fmt_i | fmt_u | fmt_r | fmt_b | fmt_j | fmt_s;
  assign rs1_en  = fmt_i | fmt_r | fmt_b | fmt_s;
  assign rs2_en  = fmt_r | fmt_b | fmt_s;
  assign rd_en   = fmt_i | fmt_u | fmt_r | fmt_j;
  assign is_load = (opcode == OP_LOAD);

  assign oAddrRs1 = rs1_en ? RAW'(iInstr[19:15]) : '0;
  assign oAddrRs2 = rs2_en ? RAW'(iInstr[24:20]) : '0;
  assign br_taken = fmt_b & br_outcome(iRs1, iRs2, iInstr[14:12]);

  always_comb begin
    imm = '0;
    if (fmt_i)      imm = sext32({{20{iInstr[31]}}, iInstr[31:20]});
    else if (fmt_s) imm = sext32({{20{iInstr[31]}}, iInstr[31:25], iInstr[11:7]});
    else if (fmt_b) imm = sext32({{19{iInstr[31]}}, iInstr[31], iInstr[7], iInstr[30:25],
                                  iInstr[11:8], 1'b0});
    else if (fmt_u) imm = sext32({iInstr[31:12], 12'b0});
    else if (fmt_j) imm = sext32({{11{iInstr[31]}}, iInstr[31], iInstr[19:12], iInstr[20],
                                  iInstr[30:21], 1'b0});
  end

  always_comb begin
    dec                = '0;
    dec.ctrl.valid     = 1'b1;
    dec.ctrl.opcode    = opcode;
    dec.ctrl.mem_en    = is_load | fmt_s;
    dec.ctrl.ex_en     = legal;
    dec.ctrl.wb_en     = rd_en & (iInstr[11:7] != 5'd0);
    dec.ctrl.imm_en    = legal & ~fmt_r;
    dec.ctrl.func3     = rs1_en ? iInstr[14:12] : 3'b000;
    dec.ctrl.func7     = fmt_r ? iInstr[31:25] : 7'b0000000;
    dec.rs1.addr       = oAddrRs1;
    dec.rs1.value      = rs1_en ? iRs1 : '0;
    dec.rs2.addr       = oAddrRs2;
    dec.rs2.value      = rs2_en ? iRs2 : '0;
    dec.rd_addr        = rd_en ? RAW'(iInstr[11:7]) : '0;
    dec.immediate      = imm;
  end

  // lat_rd is never zero while cnt is non-zero, so x0 sources never match it
  assign oHzStall = (cnt != '0) & ((rs1_en & (oAddrRs1 == lat_rd)) |
                                   (rs2_en & (oAddrRs2 == lat_rd)));
  assign oReady   = ~iFlush & (~oValid | iReady) & ~oHzStall;
  assign accept   = iValid & oReady;

  // Stage p1: registered EX request
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      oValid   <= 1'b0;
      ex_p1    <= '0;
      oPC      <= '0;
      oBrTrue  <= 1'b0;
      oIllegal <= 1'b0;
    end else if (iFlush) begin
      oValid   <= 1'b0;
    end else if (accept) begin
      oValid   <= 1'b1;
      ex_p1    <= dec;
      oPC      <= iPC;
      oBrTrue  <= br_taken;
      oIllegal <= ~legal;
    end else if (iReady) begin
      oValid   <= 1'b0;
    end
  end

  assign oEX = ex_p1;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      cnt    <= '0;
      lat_rd <= '0;
    end else if (iFlush) begin
      cnt    <= '0;
    end else if (accept & is_load & (dec.rd_addr != '0)) begin
      cnt    <= CNT_W'(LOAD_LAT);
      lat_rd <= dec.rd_addr;
    end else if (cnt != '0) begin
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule
